csr_file: RTL and testbench
===========================

// Module: csr_file
// PURPOSE
//  Machine-mode CSR storage: the receiving end of the writeback-to-CSR-file interface (wb2csrfile_*).
//  - Commits CSR writes and trap/return state updates.
//  - Runs the mcycle/minstret counters.
//  - Serves a same-cycle read port to decode (id2csrfile_*/csrfile2id_*) and trap vectoring to fetch.
// PARAMETERS
//  MHARTID    0             value returned by mhartid (0xF14)
//  MISA_VAL   32'h40000104  value returned by misa (RV32IC); writes ignored
//  MTVEC_RST  32'h0000_0000 reset value of mtvec
// PORTS
//  clk                     in   1   single clock, all state on rising edge
//  rst                     in   1   synchronous, active-high reset
//  wb2csrfile_wr_reg       in   1   CSR write strobe
//  wb2csrfile_wr_regindex  in   12  CSR address for write
//  wb2csrfile_wr_wdata     in   32  CSR write data (already RW/RS/RC-resolved upstream)
//  wb2csrfile_exp          in   1   trap taken this cycle (exception or interrupt)
//  wb2csrfile_mret         in   1   mret retiring this cycle
//  wb2csrfile_mepc         in   32  trap PC to capture
//  wb2csrfile_mtval        in   32  trap value to capture
//  wb2csrfile_causecode    in   5   cause code
//  wb2csrfile_intr         in   1   1 = cause is interrupt (mcause[31])
//  wb2csrfile_retire       in   1   one instruction retired this cycle
//  id2csrfile_rd_regindex  in   12  CSR address for read
//  csrfile2id_rdata        out  32  read data, combinational from current state
//  csrfile2id_illegal      out  1   read address unimplemented
//  csrfile2if_mtvec        out  32  mtvec (trap target)
//  csrfile2if_mepc         out  32  mepc (mret target)
//  csrfile2ex_mie          out  1   mstatus.MIE, global interrupt enable
// BEHAVIOUR
//  - Implemented CSRs: mstatus 0x300 (MIE bit3, MPIE bit7, MPP[12:11] hardwired 2'b11), misa 0x301,
//    mie 0x304, mtvec 0x305 (bits[1:0] forced 0), mscratch 0x340, mepc 0x341 (bit0 forced 0),
//    mcause 0x342, mtval 0x343, mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82,
//    cycle/cycleh 0xC00/0xC80 and instret/instreth 0xC02/0xC82 (read-only aliases), mhartid 0xF14.
//  - Reset values:
//    - mstatus MIE=0, MPIE=0; mtvec=MTVEC_RST.
//    - mie, mscratch, mepc, mcause, mtval, mcycle, minstret all 0.
//    - Outputs follow from these values.
//  - Read path:
//    - Latency 0 (combinational on id2csrfile_rd_regindex); shows pre-edge state, no write bypass.
//    - Unimplemented address -> rdata=0, illegal=1.
//    - Read-only/unimplemented write -> ignored, no error.
//  - Write path: CSR update is visible on the read port the cycle after the strobe.
//  - Priority per cycle, highest first: rst > exp > wr_reg > mret.
//    - exp: mepc<=wb2csrfile_mepc&~1, mcause<={intr,26'b0,causecode}, mtval<=wb2csrfile_mtval,
//      MPIE<=MIE, MIE<=0; any same-cycle wr_reg and mret are dropped.
//    - mret (no exp): MIE<=MPIE, MPIE<=1; a same-cycle wr_reg to mstatus wins over mret for
//      mstatus, and other CSR writes still commit.
//  - Counters are 64-bit and free-running.
//    - mcycle +1 every non-reset cycle; minstret +1 when retire=1 and exp=0.
//    - Wrap 2^64-1 -> 0 silently.
//    - A write to a counter half replaces that half; the other half holds and that cycle's
//      increment is suppressed for the whole counter.
//  - Reset asserted mid-trap clears all state; no partial commit.
// STRUCTURE
//  - Shared package/header:
//    - CSR address localparams (CSR_MSTATUS..CSR_MHARTID) and mstatus bit positions.
//    - Cause-code constants, used by decode and exception logic.
//  - One sub-module, csr_counter64: 64-bit counter with inc and per-half write-enable/data; instantiated
//    twice (mcycle, minstret).
//  - The rest is flat: address decode, register bank, trap/mret update mux.
// TESTING
//  1. Hold rst 3 cycles with wr_reg=1 -> all CSRs stay reset; mtvec read = MTVEC_RST; mcycle=0 the cycle
//     after rst drops.
//  2. Write 0x305 with 0x8000_0103 -> next-cycle read returns 0x8000_0100; csrfile2if_mtvec matches.
//  3. MIE=1, then exp with mepc=0x1235, cause 11, mtval 0xDEAD, and wr_reg to 0x340 in the same cycle ->
//     mepc=0x1234, mcause=0x0000000B, MIE=0, MPIE=1, mscratch unchanged.
//  4. mret after test 3 -> MIE=1, MPIE=1; mret with same-cycle mstatus write 0 -> mstatus MIE=0, MPIE=0.
//  5. Write mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF, then 1 idle cycle -> mcycle/mcycleh read 0/0;
//     retire+exp -> minstret unchanged.
//  6. Read 0x7C0 -> rdata=0, illegal=1; write 0xF14 then read -> MHARTID.

Source files
------------

// File: rtl/csr_file_pkg.sv
// Shared machine-mode CSR definitions: addresses, mstatus field positions, cause codes.
package csr_file_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [4:0] CAUSE_INSTR_MISALIGN = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL_INSTR  = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT     = 5'd3;
  localparam logic [4:0] CAUSE_ECALL_M        = 5'd11;
  localparam logic [4:0] CAUSE_M_SOFT_INT     = 5'd3;
  localparam logic [4:0] CAUSE_M_TIMER_INT    = 5'd7;
  localparam logic [4:0] CAUSE_M_EXT_INT      = 5'd11;

  // MPP is hardwired to machine mode; only MIE/MPIE are stored.
  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v = 32'h0000_1800;
    v[MSTATUS_MIE]  = mie;
    v[MSTATUS_MPIE] = mpie;
    return v;
  endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with independently writable halves.
// Any half write suppresses that cycle's increment for the whole counter.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 64'd0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata;
      if (wr_hi) count[63:32] <= wdata;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: commits writeback CSR writes and trap/mret updates, runs
// mcycle/minstret, and serves a combinational read port plus trap vectors.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] MHARTID   = 32'd0,
  parameter logic [31:0] MISA_VAL  = 32'h4000_0104,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb2csrfile_wr_reg,
  input  logic [11:0] wb2csrfile_wr_regindex,
  input  logic [31:0] wb2csrfile_wr_wdata,
  input  logic        wb2csrfile_exp,
  input  logic        wb2csrfile_mret,
  input  logic [31:0] wb2csrfile_mepc,
  input  logic [31:0] wb2csrfile_mtval,
  input  logic [4:0]  wb2csrfile_causecode,
  input  logic        wb2csrfile_intr,
  input  logic        wb2csrfile_retire,
  input  logic [11:0] id2csrfile_rd_regindex,
  output logic [31:0] csrfile2id_rdata,
  output logic        csrfile2id_illegal,
  output logic [31:0] csrfile2if_mtvec,
  output logic [31:0] csrfile2if_mepc,
  output logic        csrfile2ex_mie
);

  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_reg, mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0] mcycle, minstret;
  logic        wr_ok;

  // A trap in the same cycle swallows any CSR write, including counter writes.
  assign wr_ok = wb2csrfile_wr_reg && !wb2csrfile_exp;

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (wr_ok && wb2csrfile_wr_regindex == CSR_MCYCLE),
    .wr_hi (wr_ok && wb2csrfile_wr_regindex == CSR_MCYCLEH),
    .wdata (wb2csrfile_wr_wdata),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (wb2csrfile_retire && !wb2csrfile_exp),
    .wr_lo (wr_ok && wb2csrfile_wr_regindex == CSR_MINSTRET),
    .wr_hi (wr_ok && wb2csrfile_wr_regindex == CSR_MINSTRETH),
    .wdata (wb2csrfile_wr_wdata),
    .count (minstret)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_reg      <= 32'd0;
      mtvec        <= MTVEC_RST;
      mscratch     <= 32'd0;
      mepc         <= 32'd0;
      mcause       <= 32'd0;
      mtval        <= 32'd0;
    end else if (wb2csrfile_exp) begin
      mepc         <= wb2csrfile_mepc & ~32'd1;
      mcause       <= {wb2csrfile_intr, 26'd0, wb2csrfile_causecode};
      mtval        <= wb2csrfile_mtval;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else begin
      if (wr_ok) begin
        case (wb2csrfile_wr_regindex)
          CSR_MSTATUS: begin
            mstatus_mie  <= wb2csrfile_wr_wdata[MSTATUS_MIE];
            mstatus_mpie <= wb2csrfile_wr_wdata[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_reg  <= wb2csrfile_wr_wdata;
          CSR_MTVEC:    mtvec    <= wb2csrfile_wr_wdata & ~32'd3;
          CSR_MSCRATCH: mscratch <= wb2csrfile_wr_wdata;
          CSR_MEPC:     mepc     <= wb2csrfile_wr_wdata & ~32'd1;
          CSR_MCAUSE:   mcause   <= wb2csrfile_wr_wdata;
          CSR_MTVAL:    mtval    <= wb2csrfile_wr_wdata;
          default: ;
        endcase
      end
      // An explicit mstatus write in the same cycle takes precedence over mret.
      if (wb2csrfile_mret && !(wr_ok && wb2csrfile_wr_regindex == CSR_MSTATUS)) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

  always_comb begin
    csrfile2id_rdata   = 32'd0;
    csrfile2id_illegal = 1'b0;
    case (id2csrfile_rd_regindex)
      CSR_MSTATUS:               csrfile2id_rdata = mstatus_pack(mstatus_mie, mstatus_mpie);
      CSR_MISA:                  csrfile2id_rdata = MISA_VAL;
      CSR_MIE:                   csrfile2id_rdata = mie_reg;
      CSR_MTVEC:                 csrfile2id_rdata = mtvec;
      CSR_MSCRATCH:              csrfile2id_rdata = mscratch;
      CSR_MEPC:                  csrfile2id_rdata = mepc;
      CSR_MCAUSE:                csrfile2id_rdata = mcause;
      CSR_MTVAL:                 csrfile2id_rdata = mtval;
      CSR_MCYCLE,   CSR_CYCLE:   csrfile2id_rdata = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:  csrfile2id_rdata = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET: csrfile2id_rdata = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: csrfile2id_rdata = minstret[63:32];
      CSR_MHARTID:               csrfile2id_rdata = MHARTID;
      default:                   csrfile2id_illegal = 1'b1;
    endcase
  end

  assign csrfile2if_mtvec = mtvec;
  assign csrfile2if_mepc  = mepc;
  assign csrfile2ex_mie   = mstatus_mie;

endmodule

// File: tb/tb_csr_file.sv
// Randomized bench for csr_file against a behavioural CSR model, plus directed trap/counter cases.
module tb_csr_file;

  localparam logic [31:0] HART  = 32'h0000_0005;
  localparam logic [31:0] MISA  = 32'h4000_0104;
  localparam logic [31:0] TVRST = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, wr_reg, exp_i, mret, intr, retire;
  logic [11:0] wr_idx, rd_idx;
  logic [31:0] wdata, mepc_i, mtval_i;
  logic [4:0]  cause_i;
  logic [31:0] rdata, if_mtvec, if_mepc;
  logic        illegal, ex_mie;

  int n_checks = 0;
  int n_fail   = 0;

  csr_file #(.MHARTID(HART), .MISA_VAL(MISA), .MTVEC_RST(TVRST)) dut (
    .clk(clk), .rst(rst),
    .wb2csrfile_wr_reg(wr_reg), .wb2csrfile_wr_regindex(wr_idx), .wb2csrfile_wr_wdata(wdata),
    .wb2csrfile_exp(exp_i), .wb2csrfile_mret(mret), .wb2csrfile_mepc(mepc_i),
    .wb2csrfile_mtval(mtval_i), .wb2csrfile_causecode(cause_i), .wb2csrfile_intr(intr),
    .wb2csrfile_retire(retire), .id2csrfile_rd_regindex(rd_idx),
    .csrfile2id_rdata(rdata), .csrfile2id_illegal(illegal),
    .csrfile2if_mtvec(if_mtvec), .csrfile2if_mepc(if_mepc), .csrfile2ex_mie(ex_mie)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural state as plain variables and 64-bit integers.
  logic        m_mie, m_mpie;
  logic [31:0] m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;
  longint unsigned m_cyc, m_ins;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [32:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b0, 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3)};
      12'h301: return {1'b0, MISA};
      12'h304: return {1'b0, m_ie};
      12'h305: return {1'b0, m_tvec};
      12'h340: return {1'b0, m_scratch};
      12'h341: return {1'b0, m_epc};
      12'h342: return {1'b0, m_cause};
      12'h343: return {1'b0, m_tval};
      12'hB00, 12'hC00: return {1'b0, m_cyc[31:0]};
      12'hB80, 12'hC80: return {1'b0, m_cyc[63:32]};
      12'hB02, 12'hC02: return {1'b0, m_ins[31:0]};
      12'hB82, 12'hC82: return {1'b0, m_ins[63:32]};
      12'hF14: return {1'b0, HART};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic model_step();
    longint unsigned cyc_n, ins_n;
    if (rst) begin
      m_mie = 0; m_mpie = 0; m_ie = 0; m_tvec = TVRST; m_scratch = 0;
      m_epc = 0; m_cause = 0; m_tval = 0; m_cyc = 0; m_ins = 0;
      return;
    end
    cyc_n = m_cyc + 1;
    ins_n = m_ins + ((retire && !exp_i) ? 1 : 0);
    if (exp_i) begin
      m_epc = {mepc_i[31:1], 1'b0};
      m_cause = (intr ? 32'h8000_0000 : 32'd0) + 32'(cause_i);
      m_tval = mtval_i;
      m_mpie = m_mie; m_mie = 0;
    end else begin
      if (mret && !(wr_reg && wr_idx == 12'h300)) begin
        m_mie = m_mpie; m_mpie = 1;
      end
      if (wr_reg) begin
        case (wr_idx)
          12'h300: begin m_mie = wdata[3]; m_mpie = wdata[7]; end
          12'h304: m_ie = wdata;
          12'h305: m_tvec = {wdata[31:2], 2'b00};
          12'h340: m_scratch = wdata;
          12'h341: m_epc = {wdata[31:1], 1'b0};
          12'h342: m_cause = wdata;
          12'h343: m_tval = wdata;
          12'hB00: cyc_n = {m_cyc[63:32], wdata};
          12'hB80: cyc_n = {wdata, m_cyc[31:0]};
          12'hB02: ins_n = {m_ins[63:32], wdata};
          12'hB82: ins_n = {wdata, m_ins[31:0]};
          default: ;
        endcase
      end
    end
    m_cyc = cyc_n;
    m_ins = ins_n;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    rst = 0; wr_reg = 0; exp_i = 0; mret = 0; retire = 0; intr = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wr_reg = 1; wr_idx = a; wdata = d;
  endtask

  task automatic rd_const(input string tag, input logic [11:0] a, input logic [31:0] want);
    rd_idx = a; #1;
    check(tag, rdata, want);
  endtask

  task automatic rd_model(input string tag, input logic [11:0] a);
    logic [32:0] e;
    rd_idx = a; #1;
    e = model_read(a);
    check({tag, "_data"}, rdata, e[31:0]);
    check({tag, "_illegal"}, 32'(illegal), 32'(e[32]));
  endtask

  task automatic outs_model();
    check("mtvec_out", if_mtvec, m_tvec);
    check("mepc_out", if_mepc, m_epc);
    check("mie_out", 32'(ex_mie), 32'(m_mie));
  endtask

  logic [11:0] pool [0:19] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                              12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                              12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h000, 12'h344};

  initial begin
    idle();
    wr_idx = 0; wdata = 0; mepc_i = 0; mtval_i = 0; cause_i = 0; rd_idx = 12'h305;
    // Reset held with a write pending: nothing may commit.
    rst = 1; wr(12'h305, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) tick();
    idle();
    rd_const("rst_mtvec", 12'h305, TVRST);
    rd_const("rst_mcycle", 12'hB00, 32'd0);
    rd_const("rst_mstatus", 12'h300, 32'h0000_1800);
    tick();
    rd_const("mcycle_one", 12'hB00, 32'd1);

    wr(12'h305, 32'h8000_0103); tick(); idle();
    rd_const("mtvec_wr", 12'h305, 32'h8000_0100);
    check("mtvec_port", if_mtvec, 32'h8000_0100);

    wr(12'h300, 32'h0000_0008); tick(); idle();
    check("mie_set", 32'(ex_mie), 32'd1);
    exp_i = 1; mepc_i = 32'h1235; cause_i = 5'd11; mtval_i = 32'hDEAD; wr(12'h340, 32'h5555_5555);
    tick(); idle();
    rd_const("trap_mepc", 12'h341, 32'h0000_1234);
    rd_const("trap_mcause", 12'h342, 32'h0000_000B);
    rd_const("trap_mtval", 12'h343, 32'h0000_DEAD);
    rd_const("trap_mstatus", 12'h300, 32'h0000_1880);
    rd_const("trap_mscratch", 12'h340, 32'd0);

    mret = 1; tick(); idle();
    rd_const("mret_mstatus", 12'h300, 32'h0000_1888);
    mret = 1; wr(12'h300, 32'd0); tick(); idle();
    rd_const("mret_wr_mstatus", 12'h300, 32'h0000_1800);

    wr(12'hB00, 32'hFFFF_FFFF); tick();
    wr(12'hB80, 32'hFFFF_FFFF); tick(); idle();
    rd_const("pre_wrap_lo", 12'hB00, 32'hFFFF_FFFF);
    tick();
    rd_const("wrap_lo", 12'hB00, 32'd0);
    rd_const("wrap_hi", 12'hB80, 32'd0);
    retire = 1; exp_i = 1; tick(); idle();
    rd_const("retire_exp", 12'hB02, 32'd0);

    rd_const("unimpl_data", 12'h7C0, 32'd0);
    check("unimpl_illegal", 32'(illegal), 32'd1);
    wr(12'hF14, 32'hFFFF_FFFF); tick(); idle();
    rd_const("mhartid", 12'hF14, HART);
    rd_const("misa", 12'h301, MISA);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 99) == 0);
      wr_reg = ($urandom_range(0, 2) == 0);
      wr_idx = pool[$urandom_range(0, 19)];
      case ($urandom_range(0, 3))
        0: wdata = 32'hFFFF_FFFF;
        1: wdata = 32'hFFFF_FFFE;
        default: wdata = $urandom;
      endcase
      exp_i   = ($urandom_range(0, 7) == 0);
      mret    = ($urandom_range(0, 5) == 0);
      retire  = $urandom_range(0, 1) == 1;
      intr    = $urandom_range(0, 1) == 1;
      cause_i = 5'($urandom);
      mepc_i  = $urandom;
      mtval_i = $urandom;
      rd_model("rand_rd", pool[$urandom_range(0, 19)]);
      outs_model();
      tick();
    end
    idle();
    rd_model("final_cyc", 12'hC80);
    rd_model("final_ins", 12'hC02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
